// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline stage buffer.
package pipe_pkg;

  typedef struct packed {
    logic freeze;
    logic flush;
  } pipe_ctrl_t;

  localparam logic PIPE_RST_DATA = '0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+data register of the elastic buffer with local
// advance/ready handshake logic.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  pipe_ctrl_t        ctrl,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              next_ready,
  output logic              valid,
  output logic              ready,
  output logic [DATA_W-1:0] data
);
  logic advance;

  assign advance = valid && next_ready;
  assign ready   = !valid || advance;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= {DATA_W{PIPE_RST_DATA}};
    end else if (ctrl.flush) begin
      valid <= 1'b0;
    end else if (!ctrl.freeze) begin
      if (load_valid && ready) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (advance) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline buffer: DEPTH slots, freeze, flush, count.
// Define PIPE_SKID_EN to add a registered-ready input skid entry.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = clog2(DEPTH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);
  pipe_ctrl_t        ctrl;
  logic              hold;
  logic              head_go;
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  next_ready;
  logic [DEPTH-1:0]  load_valid;
  logic [DATA_W-1:0] load_data [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              in_fire;
  logic              out_fire;

  assign ctrl      = '{freeze: freeze, flush: flush};
  assign hold      = ctrl.freeze || ctrl.flush;
  assign head_go   = out_ready && !hold;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = valid[DEPTH-1] && !ctrl.freeze;
  assign out_data  = data[DEPTH-1];
  assign out_fire  = valid[DEPTH-1] && head_go;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    if (i == 0) begin : g_src
      assign load_valid[i] = src_valid;
      assign load_data[i]  = src_data;
    end else begin : g_chain
      assign load_valid[i] = valid[i-1] && ready[i];
      assign load_data[i]  = data[i-1];
    end
    // a slot may move when any slot ahead is empty or the head drains
    if (i == DEPTH - 1) begin : g_head
      assign next_ready[i] = head_go;
    end else begin : g_body
      assign next_ready[i] = head_go || !(&valid[DEPTH-1:i+1]);
    end
    pipe_slot #(.DATA_W(DATA_W)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .ctrl       (ctrl),
      .load_valid (load_valid[i]),
      .load_data  (load_data[i]),
      .next_ready (next_ready[i]),
      .valid      (valid[i]),
      .ready      (ready[i]),
      .data       (data[i])
    );
  end

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;

  assign in_ready  = !skid_valid && !hold;
  assign src_valid = skid_valid || in_fire;
  assign src_data  = skid_valid ? skid_data : in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_valid <= 1'b0;
      skid_data  <= {DATA_W{PIPE_RST_DATA}};
    end else if (ctrl.flush) begin
      skid_valid <= 1'b0;
    end else if (!ctrl.freeze) begin
      if (in_fire && !ready[0]) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end else if (skid_valid && ready[0]) begin
        skid_valid <= 1'b0;
      end
    end
  end
`else
  assign in_ready  = ready[0] && !hold;
  assign src_valid = in_fire;
  assign src_data  = in_data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (ctrl.flush) begin
      count <= '0;
    end else if (!ctrl.freeze) begin
      count <= count + CNT_W'(in_fire) - CNT_W'(out_fire);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vector table, corner sequences and
// a randomized queue scoreboard. Follows PIPE_SKID_EN when defined.
`timescale 1ns/1ps
module tb_pipe_stage_buf;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 3;
  localparam int CW     = $clog2(DEPTH + 2);
`ifdef PIPE_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif
  localparam int CAP  = DEPTH + SKID;
  localparam int NVEC = 25;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        ordy;
    logic        fz;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    int          e_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    int          stamp;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              freeze = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     count;

  int   checks = 0;
  int   errors = 0;
  vec_t vt [NVEC];
  ent_t q [$];
  ent_t h;
  int   tick, acc, got, lat, pct;
  logic seen, found, rv, rordy, rfz, rfl, exp_ir, in_fire, out_fire;
  logic [31:0] rd;

  pipe_stage_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .freeze    (freeze),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic ordy, input logic fz, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    freeze    = fz;
    flush     = fl;
    #1;
  endtask

  initial begin
    // streaming rows: beat k enters at cycle k-1, heads at k-1+DEPTH
    for (int c = 0; c < 15; c++) begin
      vt[c].v     = (c < 10);
      vt[c].d     = (c < 10) ? 32'(c + 1) : 32'h0;
      vt[c].ordy  = 1'b1;
      vt[c].fz    = 1'b0;
      vt[c].fl    = 1'b0;
      vt[c].e_ir  = 1'b1;
      vt[c].e_ov  = (c >= DEPTH) && (c <= DEPTH + 9);
      vt[c].e_od  = 32'(c - DEPTH + 1);
      vt[c].e_cnt = ((c < 10) ? c : 10)
                  - (((c < DEPTH + 10) ? c : DEPTH + 10) > DEPTH ?
                     ((c < DEPTH + 10) ? c : DEPTH + 10) - DEPTH : 0);
    end
    // freeze rows: two beats in flight, four frozen cycles, drain
    vt[15] = '{1'b1, 32'h21, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0};
    vt[16] = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1};
    for (int c = 17; c < 21; c++)
      vt[c] = '{1'b1, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2};
    vt[21] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2};
    vt[22] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h21, 2};
    vt[23] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 1};
    vt[24] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0};

    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1);

    for (int i = 0; i < NVEC; i++) begin
      drive(vt[i].v, vt[i].d, vt[i].ordy, vt[i].fz, vt[i].fl);
      chk($sformatf("row%0d_in_ready", i), in_ready, vt[i].e_ir);
      chk($sformatf("row%0d_out_valid", i), out_valid, vt[i].e_ov);
      chk($sformatf("row%0d_count", i), count, vt[i].e_cnt);
      if (vt[i].e_ov)
        chk($sformatf("row%0d_out_data", i), out_data, vt[i].e_od);
    end

    // backpressure: fill with out_ready low, then release
    acc = 0;
    for (int c = 0; c < CAP + 3; c++) begin
      drive(1'b1, 32'hA + acc, 1'b0, 1'b0, 1'b0);
      if (in_ready) acc++;
    end
    chk("bp_accepts", acc, CAP);
    drive(1'b1, 32'hA + acc, 1'b0, 1'b0, 1'b0);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_count_full", count, CAP);
    got = 0;
    for (int c = 0; c < CAP + DEPTH + 4 && got < CAP; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      if (out_valid) begin
        chk("bp_order", out_data, 32'hA + got);
        got++;
      end
    end
    chk("bp_drained", got, CAP);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("bp_count_empty", count, 0);

    // flush beats freeze, in_valid and out_ready in the same cycle
    for (int c = 0; c < CAP + 2; c++)
      drive(1'b1, 32'hF0 + c, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h77, 1'b1, 1'b1, 1'b1);
    chk("flush_in_ready", in_ready, 0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    seen = 1'b0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      seen = seen | out_valid;
    end
    chk("flush_no_ghost", seen, 0);
    chk("flush_count_after", count, 0);

    // asynchronous reset between edges, mid-stream
    for (int c = 0; c < 4; c++)
      drive(1'b1, 32'h30 + c, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_out_valid", out_valid, 0);
    chk("areset_count", count, 0);
    chk("areset_out_data", out_data, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    drive(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    chk("areset_in_ready", in_ready, 1);
    lat = 0;
    found = 1'b0;
    for (int c = 0; c < DEPTH + 3 && !found; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      lat++;
      found = out_valid;
    end
    chk("areset_latency", lat, DEPTH);
    chk("areset_data", out_data, 32'h55);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("areset_drained", count, 0);

    // random traffic against a queue scoreboard
    q.delete();
    tick = 0;
    for (int c = 0; c < 10000; c++) begin
      pct   = ((c / 1000) % 2 == 1) ? 30 : 80;
      rv    = ($urandom_range(0, 99) < 60);
      rordy = ($urandom_range(0, 99) < pct);
      rfz   = ($urandom_range(0, 99) < 8);
      rfl   = ($urandom_range(0, 99) < 2);
      rd    = $urandom;
      drive(rv, rd, rordy, rfz, rfl);
      exp_ir = !rfz && !rfl && ((q.size() < CAP) || (SKID == 0 && rordy));
      chk("rnd_count", count, q.size());
      chk("rnd_in_ready", in_ready, exp_ir);
      if (rfz) chk("rnd_freeze_out_valid", out_valid, 0);
      if (out_valid) begin
        chk("rnd_no_ghost", q.size() != 0, 1);
        if (q.size() != 0) chk("rnd_order", out_data, q[0].d);
      end
      if (!rfz && q.size() != 0 && tick - q[0].stamp >= DEPTH - 1 + SKID)
        chk("rnd_head_live", out_valid, 1);
      in_fire  = rv && in_ready;
      out_fire = out_valid && rordy && !rfl;
      if (rfl) begin
        q.delete();
      end else if (!rfz) begin
        tick++;
        if (out_fire && q.size() != 0) begin
          void'(q.pop_front());
          if (q.size() != 0) begin
            h = q[0];
            h.stamp = tick;
            q[0] = h;
          end
        end
        if (in_fire) q.push_back('{rd, tick});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
